// File: rtl/div_sequencer.sv
// Multi-cycle sequencer for RV32M DIV/DIVU/REM/REMU. A radix-2 restoring divider
// produces one quotient bit per cycle while the pipeline is held in stall.
//
// state | meaning
// IDLE  | waiting for a division in EX
// PREP  | magnitudes, sign flags, special-case detection
// ITER  | one restoring step per cycle, counter runs WIDTH..1
// DONE  | result/valid presented for one cycle
module div_sequencer #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       Funct3,
  input  logic [WIDTH-1:0] SrcA,
  input  logic [WIDTH-1:0] SrcB,
  input  logic             flush,
  output logic             stall,
  output logic             busy,
  output logic             valid,
  output logic [WIDTH-1:0] result
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, PREP, ITER, DONE} state_t;

  state_t           state, state_nx;
  logic [2:0]       op_f3;
  logic [WIDTH-1:0] op_a, op_b;
  logic [WIDTH-1:0] quo, dvs, rem;
  logic [CW-1:0]    cnt;
  logic             neg_q, neg_r;

  logic             is_signed, sel_rem, a_neg, b_neg, div_zero, ovf, take, last_iter;
  logic [WIDTH-1:0] a_mag, b_mag, rem_nx, quo_nx, q_fin, r_fin;
  logic [WIDTH:0]   shifted, diff;

  assign is_signed = (op_f3 == 3'b100) || (op_f3 == 3'b110);
  assign sel_rem   = op_f3[1];
  assign a_neg     = is_signed & op_a[WIDTH-1];
  assign b_neg     = is_signed & op_b[WIDTH-1];
  // Negating the most negative value yields its unsigned magnitude, which is what we want.
  assign a_mag     = a_neg ? (~op_a + 1'b1) : op_a;
  assign b_mag     = b_neg ? (~op_b + 1'b1) : op_b;
  assign div_zero  = (op_b == '0);
  assign ovf       = is_signed && (op_a == MOST_NEG) && (op_b == '1);

  assign shifted   = {rem, quo[WIDTH-1]};
  assign diff      = shifted - {1'b0, dvs};
  assign take      = ~diff[WIDTH];
  assign rem_nx    = take ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
  assign quo_nx    = {quo[WIDTH-2:0], take};
  assign q_fin     = neg_q ? (~quo_nx + 1'b1) : quo_nx;
  assign r_fin     = neg_r ? (~rem_nx + 1'b1) : rem_nx;
  assign last_iter = (cnt == CW'(1));

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    stall    = 1'b0;
    case (state)
      IDLE: begin
        if (start && !flush) begin
          state_nx = PREP;
          stall    = 1'b1;
        end
      end
      PREP: begin
        stall    = 1'b1;
        state_nx = (div_zero || ovf) ? DONE : ITER;
      end
      ITER: begin
        stall = 1'b1;
        if (last_iter) state_nx = DONE;
      end
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
    if (flush) state_nx = IDLE;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      op_f3  <= '0;
      op_a   <= '0;
      op_b   <= '0;
      quo    <= '0;
      dvs    <= '0;
      rem    <= '0;
      cnt    <= '0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      busy   <= 1'b0;
      valid  <= 1'b0;
      result <= '0;
    end else begin
      busy  <= (state_nx != IDLE);
      valid <= 1'b0;
      case (state)
        IDLE: begin
          if (start && !flush) begin
            op_f3 <= Funct3;
            op_a  <= SrcA;
            op_b  <= SrcB;
          end
        end
        PREP: begin
          quo   <= a_mag;
          dvs   <= b_mag;
          rem   <= '0;
          cnt   <= CW'(WIDTH);
          neg_q <= a_neg ^ b_neg;
          neg_r <= a_neg;
          if (!flush && div_zero) begin
            valid  <= 1'b1;
            result <= sel_rem ? op_a : '1;
          end else if (!flush && ovf) begin
            valid  <= 1'b1;
            result <= sel_rem ? '0 : op_a;
          end
        end
        ITER: begin
          rem <= rem_nx;
          quo <= quo_nx;
          cnt <= cnt - CW'(1);
          // Final step: sign-correct the freshly computed bits so result is ready in DONE.
          if (last_iter && !flush) begin
            valid  <= 1'b1;
            result <= sel_rem ? r_fin : q_fin;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_div_sequencer.sv
// Self-checking bench for div_sequencer: expected results are queued when an
// operation is issued and compared whenever valid is seen.
module tb_div_sequencer;

  logic        clk = 1'b0;
  logic        reset, start, flush;
  logic [2:0]  Funct3;
  logic [31:0] SrcA, SrcB;
  logic        stall, busy, valid;
  logic [31:0] result;

  int          n_chk = 0;
  int          n_pass = 0;
  int          cyc = 0;
  logic [31:0] exp_q[$];
  logic [31:0] last_res;

  div_sequencer #(.WIDTH(32)) dut (
    .clk(clk), .reset(reset), .start(start), .Funct3(Funct3),
    .SrcA(SrcA), .SrcB(SrcB), .flush(flush),
    .stall(stall), .busy(busy), .valid(valid), .result(result)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
  endtask

  function automatic logic [31:0] model(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    logic        sgn;
    logic [31:0] q, r;
    sgn = !f3[0];
    if (b == 32'd0) begin
      q = 32'hFFFF_FFFF; r = a;
    end else if (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      q = a; r = 32'd0;
    end else if (sgn) begin
      q = $signed(a) / $signed(b); r = $signed(a) % $signed(b);
    end else begin
      q = a / b; r = a % b;
    end
    return f3[1] ? r : q;
  endfunction

  always @(negedge clk) begin
    if (valid) begin
      if (exp_q.size() == 0) check("spurious_valid", 32'd1, 32'd0);
      else check("result", result, exp_q.pop_front());
    end
  end

  // Entered and left just after a rising edge; start is held until the DONE edge.
  task automatic do_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] exp, input int exp_lat, output int vcyc);
    int n_stall, lat;
    n_stall = 0; lat = -1; vcyc = -1;
    start = 1'b1; Funct3 = f3; SrcA = a; SrcB = b;
    exp_q.push_back(exp);
    last_res = exp;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (c == 1) check("busy_after_accept", {31'd0, busy}, 32'd1);
      if (stall) n_stall++;
      if (valid) begin
        lat = c; vcyc = cyc;
        break;
      end
      @(posedge clk); #1;
    end
    if (lat < 0) check("valid_timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
    start = 1'b0;
    check("latency", lat, exp_lat);
    check("stall_cycles", n_stall, exp_lat);
  endtask

  task automatic rand_op();
    logic [2:0]  f3;
    logic [31:0] a, b;
    int          v, lat;
    f3 = 3'b100 | 3'($urandom_range(3));
    a  = $urandom();
    b  = $urandom() >> $urandom_range(31);
    lat = (b == 0 || (!f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)) ? 2 : 34;
    do_op(f3, a, b, model(f3, a, b), lat, v);
    @(posedge clk); #1;
  endtask

  initial begin
    int v, t0;
    reset = 1'b1; start = 1'b0; flush = 1'b0;
    Funct3 = 3'b000; SrcA = '0; SrcB = '0;
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    check("reset_stall", {31'd0, stall}, 32'd0);
    check("reset_busy", {31'd0, busy}, 32'd0);
    check("reset_valid", {31'd0, valid}, 32'd0);
    check("reset_result", result, 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;

    do_op(3'b101, 32'd100, 32'd7, 32'd14, 34, v);            @(posedge clk); #1;
    do_op(3'b111, 32'd100, 32'd7, 32'd2, 34, v);             @(posedge clk); #1;
    do_op(3'b100, -32'sd100, 32'd7, 32'hFFFF_FFF2, 34, v);   @(posedge clk); #1;
    do_op(3'b110, -32'sd100, 32'd7, 32'hFFFF_FFFE, 34, v);   @(posedge clk); #1;
    do_op(3'b110, 32'd100, -32'sd7, 32'd2, 34, v);           @(posedge clk); #1;
    do_op(3'b100, 32'd5, 32'd0, 32'hFFFF_FFFF, 2, v);        @(posedge clk); #1;
    do_op(3'b111, 32'd5, 32'd0, 32'd5, 2, v);                @(posedge clk); #1;
    do_op(3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 2, v); @(posedge clk); #1;
    do_op(3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 2, v);         @(posedge clk); #1;
    do_op(3'b101, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 34, v);        @(posedge clk); #1;

    // flush mid-ITER: accepted at edge 0, flush sampled at edge 10
    start = 1'b1; Funct3 = 3'b101; SrcA = 32'hFFFF_FFFF; SrcB = 32'd1;
    repeat (10) @(posedge clk);
    #1;
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0; start = 1'b0;
    @(negedge clk);
    check("flush_stall", {31'd0, stall}, 32'd0);
    check("flush_busy", {31'd0, busy}, 32'd0);
    check("flush_valid", {31'd0, valid}, 32'd0);
    check("flush_result_kept", result, last_res);
    @(posedge clk); #1;
    do_op(3'b101, 32'd9, 32'd3, 32'd3, 34, v);
    @(posedge clk); #1;

    // reset in cycle 20 of an operation
    start = 1'b1; Funct3 = 3'b101; SrcA = 32'd1000; SrcB = 32'd3;
    repeat (20) @(posedge clk);
    #1;
    reset = 1'b1; start = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check("midreset_stall", {31'd0, stall}, 32'd0);
    check("midreset_busy", {31'd0, busy}, 32'd0);
    check("midreset_valid", {31'd0, valid}, 32'd0);
    check("midreset_result", result, 32'd0);
    @(posedge clk); #1;
    do_op(3'b111, 32'd1000, 32'd3, 32'd1, 34, v);
    @(posedge clk); #1;

    // back-to-back: second start in the idle cycle right after DONE
    t0 = cyc;
    do_op(3'b101, 32'd50, 32'd5, 32'd10, 34, v);
    check("b2b_first_cycle", v - t0, 32'd34);
    do_op(3'b111, 32'd50, 32'd6, 32'd2, 34, v);
    check("b2b_second_cycle", v - t0, 32'd69);
    @(posedge clk); #1;

    for (int i = 0; i < 6; i++) rand_op();

    repeat (5) @(posedge clk);
    check("queue_drained", exp_q.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: sim exceeded time limit");
    $fatal(1);
  end

endmodule

// File: doc/div_sequencer.md
# div_sequencer

Multi-cycle controller for RISC-V M-extension division (DIV, DIVU, REM, REMU) in the EX stage. It accepts an operation from the pipeline, stalls the pipeline while a radix-2 restoring divider iterates one quotient bit per cycle, and returns a one-cycle-valid result. Operands arrive already forwarded, so this block does no forwarding or hazard detection. The single-cycle ALU is untouched; `Funct3` selects the division variant exactly as the instruction encodes it.

## Interface
- `WIDTH`, 32, operand and result width; iteration count equals WIDTH
- `clk`  in  1  rising-edge clock
- `reset`  in  1  synchronous, active-high; returns block to IDLE
- `start`  in  1  EX holds a division instruction; level, held while `stall`=1
- `Funct3`  in  3  100 DIV, 101 DIVU, 110 REM, 111 REMU
- `SrcA`  in  WIDTH  dividend (rs1)
- `SrcB`  in  WIDTH  divisor (rs2)
- `flush`  in  1  kill in-flight operation (branch/trap)
- `stall`  out  1  freeze IF/ID/EX
- `busy`  out  1  state ≠ IDLE
- `valid`  out  1  `result` valid this cycle
- `result`  out  WIDTH  quotient or remainder

## Operation
- States: IDLE, PREP, ITER, DONE.
- IDLE: if `start`=1 and `flush`=0, latch `Funct3`, `SrcA`, `SrcB` and go to PREP. Otherwise stay in IDLE.
- PREP (1 cycle):
  - Compute magnitudes. Signed ops take abs of each operand; unsigned ops pass operands through.
  - Record sign flags: quotient negative = signs differ; remainder negative = dividend negative (signed ops only).
  - Clear the partial remainder and load the counter with WIDTH.
  - Special cases skip ITER and go straight to DONE with a preset result:
    - Divisor = 0: quotient = all ones, remainder = original dividend. Applies to signed and unsigned.
    - Signed, dividend = 1 followed by WIDTH-1 zeros (most negative) and divisor = all ones (-1): quotient = dividend, remainder = 0.
  - Otherwise go to ITER.
- ITER: each cycle shift {rem, quo} left one bit, try `rem − divisor`, keep the difference and set quotient LSB to 1 if non-negative, decrement the counter. After the cycle where the counter reaches 0, go to DONE.
- DONE (1 cycle): apply sign correction (two's complement negate), drive `result` = quotient (100/101) or remainder (110/111), assert `valid`, then return to IDLE.
- All arithmetic is WIDTH+1 bits wide internally, so the subtraction sign is exact. Abs of the most negative value is its unsigned magnitude.
- `flush`=1 in any state: go to IDLE next edge, no `valid`, `result` unchanged.
- `start` is ignored outside IDLE. A `start` still high in the DONE cycle does not restart, because it belongs to the completing instruction.
- `reset` takes priority over `flush`, and `flush` over `start`.

## Timing
- Reset values: state IDLE, `stall`=0, `busy`=0, `valid`=0, `result`=0, counter=0.
- `stall` = (IDLE & `start` & ~`flush`) | PREP | ITER.
  - The first term is combinational, so the pipeline freezes in the same cycle the instruction is presented.
  - `stall` is 0 in DONE, so the pipeline advances and consumes `result` at the DONE edge.
- `busy`, `valid` and `result` are registered.
- Normal latency, with `start` sampled at edge k:
  - PREP in cycle k+1
  - ITER in cycles k+2 .. k+1+WIDTH
  - DONE in cycle k+2+WIDTH, so `valid` is 34 cycles after the sampling edge for WIDTH=32
  - `stall` is high for 34 cycles: cycle k plus cycles k+1..k+33
- Special-case latency: DONE in cycle k+2, `stall` high for 2 cycles.
- Back-to-back divisions: the earliest next `start` acceptance is the cycle after DONE (IDLE), giving 1 idle cycle minimum between operations.
- Reset or flush mid-ITER: the counter is discarded, and the next accepted `start` behaves like a fresh operation.

## Test plan
- DIVU 100 / 7, start at edge 0 → `stall` high cycles 0–33, `valid`=1 and `result`=14 in cycle 34; REMU same operands → 2.
- DIV −100 / 7 → 0xFFFFFFF2 (−14); REM −100 / 7 → 0xFFFFFFFE (−2); REM 100 / −7 → 2.
- DIV 5 / 0 → 0xFFFFFFFF in cycle 2; REMU 5 / 0 → 5; DIV 0x80000000 / 0xFFFFFFFF → 0x80000000 and REM → 0, both in cycle 2.
- Start DIVU 0xFFFFFFFF / 1, assert `flush` in cycle 10 → IDLE at cycle 11, `stall`/`busy` low, no `valid`; new DIVU 9 / 3 at cycle 12 → 3 at cycle 46.
- `reset` asserted in cycle 20 of an operation → all outputs at reset values next cycle; `start` held high during ITER/DONE → exactly one `valid` pulse.
- Back-to-back DIVU 50 / 5 then REMU 50 / 6 → `valid` with 10 at cycle 34, `valid` with 2 at cycle 69.
